// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the debug-slave command path.
// Holds the JTAG register widths, the channel count, the FIFO pointer-width
// helper and the command entry layout that the FIFO stores.
package nios_dbg_pkg;

  localparam int IR_W      = 2;
  localparam int DR_W      = 38;
  localparam int NUM_CH    = 1 << IR_W;
  localparam int ACT_BIT   = DR_W - 1;
  localparam int DEF_DEPTH = 4;

  // One extra pointer bit separates full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [IR_W-1:0] ch;
    logic            act;
    logic [DR_W-2:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/nios_dbg_cmd_fifo.sv
// Generic first-word-fall-through FIFO.
// Ports: clk/rst (async high), push+wdata write, pop consumes the head,
// rdata is the head (holds the last popped word while empty), full/empty flags.
// The caller must not push when full unless it pops in the same cycle, and
// must not pop when empty.
module nios_dbg_cmd_fifo
  import nios_dbg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] last_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Storage carries no reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // While empty, the slot under rd_ptr is stale, so present the last popped word.
  assign rdata = empty ? last_q : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/nios_dbg_cmd_dispatch.sv
// System-clock half of the debug slave.
// Edge-detects the synchronised update-IR/update-DR strobes, latches the IR,
// turns each DR update into a command {ch, act, data}, filters on ch_en,
// queues commands in a FWFT FIFO and presents the head on a valid/ready port.
// Ports: ir_upd/ir_val, dr_upd/dr_val strobes and words; ch_en channel mask;
// cmd_valid/cmd_ready/cmd_ch/cmd_act/cmd_data command port; cap_req/rb_data/
// cap_data readback capture; ovf/ovf_clr sticky overflow flag.
module nios_dbg_cmd_dispatch
  import nios_dbg_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ir_upd,
  input  logic [IR_W-1:0]        ir_val,
  input  logic                   dr_upd,
  input  logic [DR_W-1:0]        dr_val,
  input  logic [NUM_CH-1:0]      ch_en,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [IR_W-1:0]        cmd_ch,
  output logic                   cmd_act,
  output logic [DR_W-2:0]        cmd_data,
  input  logic                   cap_req,
  input  logic [NUM_CH*DR_W-1:0] rb_data,
  output logic [DR_W-1:0]        cap_data,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  logic [IR_W-1:0]  ir_q;
  logic             ir_upd_q, dr_upd_q;
  logic             ir_rise, dr_rise;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop, dr_cmd;
  cmd_t             wr_entry, head;
  logic [CMD_W-1:0] head_raw;

  // Strobe history resets high so a strobe already asserted at reset
  // release is not mistaken for a fresh update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_upd_q <= 1'b1;
      dr_upd_q <= 1'b1;
      ir_q     <= '0;
    end else begin
      ir_upd_q <= ir_upd;
      dr_upd_q <= dr_upd;
      if (ir_rise) ir_q <= ir_val;
    end
  end

  assign ir_rise = ir_upd & ~ir_upd_q;
  assign dr_rise = dr_upd & ~dr_upd_q;

  // ir_q is read before its own update, so a same-cycle IR rise does not
  // affect this DR command or this capture.
  assign dr_cmd = dr_rise & ch_en[ir_q];
  assign pop    = cmd_valid & cmd_ready;
  assign push   = dr_cmd & (~fifo_full | pop);
  assign drop   = dr_cmd & fifo_full & ~pop;

  assign wr_entry.ch   = ir_q;
  assign wr_entry.act  = dr_val[ACT_BIT];
  assign wr_entry.data = dr_val[DR_W-2:0];

  nios_dbg_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head      = head_raw;
  assign cmd_valid = ~fifo_empty;
  assign cmd_ch    = head.ch;
  assign cmd_act   = head.act;
  assign cmd_data  = head.data;

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cap_data <= '0;
    else if (cap_req) cap_data <= rb_data[int'(ir_q)*DR_W +: DR_W];
  end

endmodule
